// File: rtl/scsdpram_be_pipe.sv
// Single-clock simple-dual-port RAM with byte enables and a registered read pipeline.
// Optional per-byte even parity when SCSDPRAM_BE_PIPE_PARITY_EN is defined.
module scsdpram_be_pipe #(
    parameter  int C_WIDTH      = 32,
    parameter  int C_DEPTH      = 1024,
    parameter  int C_RD_LATENCY = 1,
    parameter  int C_RDW_MODE   = 0,
    localparam int C_BE_WIDTH   = C_WIDTH / 8,
    localparam int AW           = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RD1_EN,
    input  logic [AW-1:0]         RD1_ADDR,
    output logic [C_WIDTH-1:0]    RD1_DATA,
    output logic                  RD1_VALID,
    output logic                  RD1_PERR,
    input  logic                  WR1_EN,
    input  logic [C_BE_WIDTH-1:0] WR1_BE,
    input  logic [AW-1:0]         WR1_ADDR,
    input  logic [C_WIDTH-1:0]    WR1_DATA
);

`ifdef SCSDPRAM_BE_PIPE_PARITY_EN
    localparam int SW = C_WIDTH + C_BE_WIDTH;
`else
    localparam int SW = C_WIDTH;
`endif

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(C_DEPTH);

    generate
        if (C_RD_LATENCY < 1 || C_RD_LATENCY > 4 || (C_WIDTH % 8) != 0) begin : g_param_err
            $error("scsdpram_be_pipe: illegal C_RD_LATENCY or C_WIDTH");
        end
    endgenerate

    logic [SW-1:0] mem_q [C_DEPTH];

    logic          rd_in_rng;
    logic          wr_in_rng;
    logic          rd_ok;
    logic          wr_ok;
    logic          collide;
    logic [SW-1:0] wr_word;
    logic [SW-1:0] rd_raw;
    logic [SW-1:0] rd_word;

    logic [C_RD_LATENCY-1:0]         vld_q;
    logic [C_RD_LATENCY-1:0]         vld_d;
    logic [C_RD_LATENCY-1:0][SW-1:0] dat_q;
    logic [C_RD_LATENCY-1:0][SW-1:0] dat_d;

    // Qualify requests: reset masks both ports, out-of-range addresses never touch storage
    always_comb begin
        rd_in_rng = ({1'b0, RD1_ADDR} < DEPTH_W);
        wr_in_rng = ({1'b0, WR1_ADDR} < DEPTH_W);
        rd_ok     = RD1_EN && !RST;
        wr_ok     = WR1_EN && !RST && wr_in_rng;
        collide   = wr_ok && rd_in_rng && (WR1_ADDR == RD1_ADDR);
    end

    // Incoming write word, with one even-parity bit per byte when parity is stored
    always_comb begin
        wr_word = '0;
        wr_word[C_WIDTH-1:0] = WR1_DATA;
`ifdef SCSDPRAM_BE_PIPE_PARITY_EN
        for (int i = 0; i < C_BE_WIDTH; i++) begin
            wr_word[C_WIDTH+i] = ^WR1_DATA[8*i +: 8];
        end
`endif
    end

    // Array read; out-of-range returns zero, write-first mode merges enabled bytes on collision
    always_comb begin
        rd_raw  = rd_in_rng ? mem_q[RD1_ADDR] : '0;
        rd_word = rd_raw;
        if (C_RDW_MODE == 1 && collide) begin
            for (int i = 0; i < C_BE_WIDTH; i++) begin
                if (WR1_BE[i]) begin
                    rd_word[8*i +: 8] = wr_word[8*i +: 8];
`ifdef SCSDPRAM_BE_PIPE_PARITY_EN
                    rd_word[C_WIDTH+i] = wr_word[C_WIDTH+i];
`endif
                end
            end
        end
    end

    // Byte-enabled array write; parity bits travel with their byte
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            for (int i = 0; i < C_BE_WIDTH; i++) begin
                if (WR1_BE[i]) begin
                    mem_q[WR1_ADDR][8*i +: 8] <= wr_word[8*i +: 8];
`ifdef SCSDPRAM_BE_PIPE_PARITY_EN
                    mem_q[WR1_ADDR][C_WIDTH+i] <= wr_word[C_WIDTH+i];
`endif
                end
            end
        end
    end

    // Next state of the read pipeline; a stage only loads when its upstream valid is set
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = rd_ok;
        if (rd_ok) begin
            dat_d[0] = rd_word;
        end
        for (int k = 1; k < C_RD_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    // Read pipeline registers, cleared by reset so in-flight reads are dropped
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign RD1_VALID = vld_q[C_RD_LATENCY-1];
    assign RD1_DATA  = dat_q[C_RD_LATENCY-1][C_WIDTH-1:0];

`ifdef SCSDPRAM_BE_PIPE_PARITY_EN
    logic perr;

    // Recheck parity on the output word; flag only alongside a valid result
    always_comb begin
        perr = 1'b0;
        for (int i = 0; i < C_BE_WIDTH; i++) begin
            perr = perr | ((^dat_q[C_RD_LATENCY-1][8*i +: 8]) ^ dat_q[C_RD_LATENCY-1][C_WIDTH+i]);
        end
    end

    assign RD1_PERR = RD1_VALID & perr;
`else
    assign RD1_PERR = 1'b0;
`endif

endmodule

// File: tb/tb_scsdpram_be_pipe.sv
// Bench for scsdpram_be_pipe: two instances (read-first/latency 1/depth 1024 and
// write-first/latency 4/depth 1000) driven by shared stimulus against a reference model.
module tb_scsdpram_be_pipe;

    localparam int L0 = 1;
    localparam int L1 = 4;
    localparam int M0 = 0;
    localparam int M1 = 1;
    localparam int D0 = 1024;
    localparam int D1 = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [9:0]  rd_addr;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    logic [31:0] d0_data;
    logic [31:0] d1_data;
    logic        d0_v;
    logic        d1_v;
    logic        d0_p;
    logic        d1_p;

    int npass = 0;
    int ntot  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [31:0] mm    [2][1024];
    logic        sv    [2][8];
    logic [31:0] sd    [2][8];
    logic [31:0] hold  [2];
    logic        expv  [2];

    always #5 clk = ~clk;

    scsdpram_be_pipe #(
        .C_WIDTH(32), .C_DEPTH(D0), .C_RD_LATENCY(L0), .C_RDW_MODE(M0)
    ) d0 (
        .CLK(clk), .RST(rst),
        .RD1_EN(rd_en), .RD1_ADDR(rd_addr),
        .RD1_DATA(d0_data), .RD1_VALID(d0_v), .RD1_PERR(d0_p),
        .WR1_EN(wr_en), .WR1_BE(wr_be), .WR1_ADDR(wr_addr), .WR1_DATA(wr_data)
    );

    scsdpram_be_pipe #(
        .C_WIDTH(32), .C_DEPTH(D1), .C_RD_LATENCY(L1), .C_RDW_MODE(M1)
    ) d1 (
        .CLK(clk), .RST(rst),
        .RD1_EN(rd_en), .RD1_ADDR(rd_addr),
        .RD1_DATA(d1_data), .RD1_VALID(d1_v), .RD1_PERR(d1_p),
        .WR1_EN(wr_en), .WR1_BE(wr_be), .WR1_ADDR(wr_addr), .WR1_DATA(wr_data)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // What each instance should do at this edge, from the behavioural rules
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int lat;
            int dep;
            int mode;
            logic [31:0] w;
            lat  = (k == 0) ? L0 : L1;
            dep  = (k == 0) ? D0 : D1;
            mode = (k == 0) ? M0 : M1;
            if (rst) begin
                for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
                hold[k] = '0;
                expv[k] = 1'b0;
            end else begin
                if (rd_en) begin
                    w = (int'(rd_addr) < dep) ? mm[k][rd_addr] : 32'h0;
                    if (mode == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < dep)
                        w = merge(w, wr_data, wr_be);
                    sv[k][(cyc + lat - 1) % 8] = 1'b1;
                    sd[k][(cyc + lat - 1) % 8] = w;
                end
                expv[k] = sv[k][cyc % 8];
                if (expv[k]) hold[k] = sd[k][cyc % 8];
                sv[k][cyc % 8] = 1'b0;
                if (wr_en && int'(wr_addr) < dep)
                    mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_be);
            end
        end
    endtask

    task automatic check_outputs();
        chk("d0_valid", {31'b0, d0_v}, {31'b0, expv[0]});
        chk("d0_data",  d0_data, hold[0]);
        chk("d0_perr",  {31'b0, d0_p}, 32'h0);
        chk("d1_valid", {31'b0, d1_v}, {31'b0, expv[1]});
        chk("d1_data",  d1_data, hold[1]);
        chk("d1_perr",  {31'b0, d1_p}, 32'h0);
    endtask

    task automatic step(input bit do_chk);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (do_chk) check_outputs();
    endtask

    task automatic drv(input logic r, input logic re, input logic [9:0] ra,
                       input logic we, input logic [9:0] wa, input logic [31:0] wd,
                       input logic [3:0] be);
        rst = r; rd_en = re; rd_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        step(1'b1);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 4'h0);
    endtask

    function automatic logic [9:0] rnd_addr();
        int a;
        a = $urandom_range(0, 55);
        return (a < 32) ? 10'(a) : 10'(1000 + a - 32);
    endfunction

    initial begin
        int cnt0;
        int cnt1;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 8; s++) begin
                sv[k][s] = 1'b0;
                sd[k][s] = '0;
            end

        // Reset
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, 10'd3, 1'b1, 10'd3, 32'h12345678, 4'hF);
        chk("rst_d0_data", d0_data, 32'h0);
        chk("rst_d1_valid", {31'b0, d1_v}, 32'h0);

        // Initialise every address the bench ever reads
        for (int a = 0; a < 56; a++) begin
            logic [9:0] ad;
            ad = (a < 32) ? 10'(a) : 10'(1000 + a - 32);
            drv(1'b0, 1'b0, 10'd0, 1'b1, ad, $urandom, 4'hF);
        end

        // Full write then read, both latencies
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        drv(1'b0, 1'b1, 10'd5, 1'b0, 10'd0, 32'h0, 4'h0);
        chk("t1_d0", d0_data, 32'hDEADBEEF);
        chk("t1_d0_v", {31'b0, d0_v}, 32'h1);
        for (int i = 0; i < 3; i++) idle();
        chk("t1_d1", d1_data, 32'hDEADBEEF);
        chk("t1_d1_v", {31'b0, d1_v}, 32'h1);

        // Partial byte-enable write
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd7, 32'h11223344, 4'hF);
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0101);
        drv(1'b0, 1'b1, 10'd7, 1'b0, 10'd0, 32'h0, 4'h0);
        chk("t2_d0", d0_data, 32'h11BB33DD);
        for (int i = 0; i < 3; i++) idle();
        chk("t2_d1", d1_data, 32'h11BB33DD);

        // Same-address collision
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd9, 32'h0, 4'hF);
        drv(1'b0, 1'b1, 10'd9, 1'b1, 10'd9, 32'hFFFFFFFF, 4'hF);
        chk("t3_d0_old", d0_data, 32'h0);
        for (int i = 0; i < 3; i++) idle();
        chk("t3_d1_new", d1_data, 32'hFFFFFFFF);
        drv(1'b0, 1'b1, 10'd9, 1'b0, 10'd0, 32'h0, 4'h0);
        chk("t3_d0_after", d0_data, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) idle();

        // Back-to-back burst
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 16; i++) begin
            drv(1'b0, 1'b1, 10'(i), 1'b0, 10'd0, 32'h0, 4'h0);
            cnt0 += int'(d0_v);
            cnt1 += int'(d1_v);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            cnt0 += int'(d0_v);
            cnt1 += int'(d1_v);
        end
        chk("t4_cnt_d0", 32'(cnt0), 32'd16);
        chk("t4_cnt_d1", 32'(cnt1), 32'd16);

        // Reset in the middle of a burst
        for (int i = 0; i < 8; i++) drv(1'b0, 1'b1, 10'(i), 1'b0, 10'd0, 32'h0, 4'h0);
        cnt1 = 0;
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 1'b1, 10'(i), 1'b0, 10'd0, 32'h0, 4'h0);
            cnt1 += int'(d1_v) + int'(d0_v);
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            cnt1 += int'(d1_v) + int'(d0_v);
        end
        chk("t4_rst_drop", 32'(cnt1), 32'd0);

        // Out-of-range address on the depth-1000 instance
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd1005, 32'hCAFEF00D, 4'hF);
        drv(1'b0, 1'b1, 10'd1005, 1'b0, 10'd0, 32'h0, 4'h0);
        chk("t5_d0_inrange", d0_data, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) idle();
        chk("t5_d1_zero", d1_data, 32'h0);
        chk("t5_d1_v", {31'b0, d1_v}, 32'h1);
        drv(1'b0, 1'b1, 10'd5, 1'b0, 10'd0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) idle();
        chk("t5_d1_addr5", d1_data, 32'hDEADBEEF);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drv(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, rnd_addr(),
                $urandom_range(0, 1) == 1, rnd_addr(), $urandom, 4'($urandom));
        end
        for (int i = 0; i < 5; i++) idle();

`ifdef SCSDPRAM_BE_PIPE_PARITY_EN
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd5, 32'h0F0F1234, 4'hF);
        drv(1'b0, 1'b0, 10'd0, 1'b1, 10'd6, 32'h55AA00FF, 4'hF);
        d0.mem_q[5][3] = ~d0.mem_q[5][3];
        rst = 1'b0; rd_en = 1'b1; rd_addr = 10'd5; wr_en = 1'b0;
        step(1'b0);
        chk("t6_perr", {31'b0, d0_p}, 32'h1);
        chk("t6_perr_v", {31'b0, d0_v}, 32'h1);
        rd_addr = 10'd6;
        step(1'b0);
        chk("t6_clean", {31'b0, d0_p}, 32'h0);
        rd_en = 1'b0;
        step(1'b0);
        chk("t6_idle", {31'b0, d0_p}, 32'h0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
